// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / jr hazard detection, stall and flush control with stall watchdog and perf counters
module hazard_ctrl #(
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_is_jr,
    input  logic             ID_is_jump,
    input  logic             EX_memread,
    input  logic             EX_regwrite,
    input  logic [4:0]       EX_rd,
    input  logic             MEM_memread,
    input  logic             MEM_regwrite,
    input  logic [4:0]       MEM_rd,
    input  logic             EX_branch_taken,
    output logic             PCwrite,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    localparam int RLW = ($clog2(MAX_STALL + 2) > 3) ? $clog2(MAX_STALL + 2) : 3;
    localparam logic [RLW-1:0] RUN_MAX = RLW'(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        JR_STALL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RLW-1:0]   run_len_q, run_len_d;
    logic             stall_err_q, stall_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu, jh, stall, flush_norm;

    // MEM-stage ALU results are forwarded into ID, so a MEM regwrite never stalls a jr.
    logic unused_mem_regwrite;
    assign unused_mem_regwrite = MEM_regwrite;

    assign lu = EX_memread && (EX_rd != 5'd0) &&
                ((EX_rd == ID_rs) || (ID_uses_rt && (EX_rd == ID_rt)));

    assign jh = ID_is_jr && (ID_rs != 5'd0) &&
                ((EX_regwrite && (EX_rd == ID_rs)) || (MEM_memread && (MEM_rd == ID_rs)));

    assign stall = (lu || jh) && !EX_branch_taken;

    // IF/ID is zeroed by a taken branch or by a jump that is not held back by a stall.
    assign flush_norm = EX_branch_taken || (!stall && ID_is_jump);

    // Pipeline controls: reset forces a frozen, fully flushed pipe; otherwise branch > stall > jump.
    always_comb begin
        PCwrite     = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        if (!rst) begin
            PCwrite     = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (stall) begin
            PCwrite     = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (ID_is_jump) begin
            IF_ID_flush = 1'b1;
        end
    end

    // Next state of the stall-episode tracker; an episode starts at 1 when entered from RUN.
    always_comb begin
        state_d   = RUN;
        run_len_d = '0;
        if (stall) begin
            state_d = lu ? LU_STALL : JR_STALL;
            if (state_q == RUN) begin
                run_len_d = RLW'(1);
            end else if (run_len_q != RUN_MAX) begin
                run_len_d = run_len_q + RLW'(1);
            end else begin
                run_len_d = run_len_q;
            end
        end
        stall_err_d = stall_err_q || (run_len_d == RUN_MAX);
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_norm && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Stall FSM, episode length and sticky watchdog flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            run_len_q   <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign stall_err = stall_err_q;

endmodule
